// File: rtl/mux_scan_n1_pkg.sv
// rtl/mux_scan_n1_pkg.sv - mode encodings and helpers shared by the N:1 scan selector
package mux_scan_n1_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   localparam int MODE_W = 2;

   function automatic logic mode_is_scan(input logic [MODE_W-1:0] m);
      return m == MODE_SCAN;
   endfunction

   function automatic logic mode_is_manual(input logic [MODE_W-1:0] m);
      return m == MODE_MANUAL;
   endfunction

endpackage

// File: rtl/mux_n1.sv
// rtl/mux_n1.sv - combinational N:1 data select of W-bit channels
module mux_n1 #(
   parameter int N    = 16,
   parameter int W    = 1,
   parameter int SELW = $clog2(N)
) (
   input  logic [N*W-1:0]  w,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    y
);

   // Out-of-range selects yield zero; the caller never registers them.
   always_comb begin
      y = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) y = w[k*W +: W];
      end
   end

endmodule

// File: rtl/mux_scan_n1.sv
// rtl/mux_scan_n1.sv - registered N:1 channel selector with manual, dwell-scan and hold modes
module mux_scan_n1
   import mux_scan_n1_pkg::*;
#(
   parameter int N     = 16,
   parameter int W     = 1,
   parameter int SELW  = $clog2(N),
   parameter int DWELL = 4
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [N*W-1:0]    w,
   input  logic [SELW-1:0]   s,
   input  logic [1:0]        mode,
   input  logic [N-1:0]      en_mask,
   input  logic              out_ready,
   output logic [W-1:0]      f,
   output logic              f_valid,
   output logic [SELW-1:0]   f_ch,
   output logic              sel_err
);

   localparam int CNTW = $clog2(DWELL + 1);

   logic [W-1:0]    f_q, f_d;
   logic            f_valid_q, f_valid_d;
   logic [SELW-1:0] f_ch_q, f_ch_d;
   logic            sel_err_q, sel_err_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [1:0]      mode_q, mode_d;

   logic            load;
   logic            mode_chg;
   logic [SELW-1:0] base_ptr;
   logic [CNTW-1:0] base_cnt;
   logic            skip;
   logic [SELW-1:0] samp_ptr;
   logic [CNTW-1:0] samp_cnt;
   logic [CNTW-1:0] cnt_inc;
   logic [SELW-1:0] mux_sel;
   logic [W-1:0]    mux_y;

   // First enabled channel strictly above p, wrapping; returns p itself if it is the only one.
   function automatic logic [SELW-1:0] next_en(input logic [N-1:0] m, input logic [SELW-1:0] p);
      logic [SELW-1:0] r;
      logic            found;
      int              idx;
      r     = p;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(p) + i) % N;
         if (!found && m[idx]) begin
            r     = SELW'(idx);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   mux_n1 #(.N(N), .W(W), .SELW(SELW)) u_mux (
      .w   (w),
      .sel (mux_sel),
      .y   (mux_y)
   );

   // Scan pointer resolution: mode entry restarts at the lowest enabled channel,
   // and a pointer whose channel was masked off skips forward with a fresh dwell.
   always_comb begin
      load     = !f_valid_q || out_ready;
      mode_chg = mode != mode_q;
      base_ptr = ptr_q;
      base_cnt = cnt_q;
      if (mode_chg) begin
         base_cnt = '0;
         if (mode_is_scan(mode)) base_ptr = next_en(en_mask, SELW'(N - 1));
      end
      skip     = !en_mask[base_ptr];
      samp_ptr = skip ? next_en(en_mask, base_ptr) : base_ptr;
      samp_cnt = skip ? '0 : base_cnt;
      cnt_inc  = samp_cnt + CNTW'(1);
      mux_sel  = mode_is_manual(mode) ? s : samp_ptr;
   end

   always_comb begin
      f_d       = f_q;
      f_valid_d = f_valid_q;
      f_ch_d    = f_ch_q;
      sel_err_d = sel_err_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      if (load) begin
         mode_d = mode;
         cnt_d  = base_cnt;
         case (mode)
            MODE_MANUAL: begin
               if ({1'b0, s} < (SELW + 1)'(N)) begin
                  f_d       = mux_y;
                  f_ch_d    = s;
                  f_valid_d = 1'b1;
               end else begin
                  f_valid_d = 1'b0;
                  sel_err_d = 1'b1;
               end
            end
            MODE_SCAN: begin
               if (en_mask == '0) begin
                  f_valid_d = 1'b0;
               end else begin
                  f_d       = mux_y;
                  f_ch_d    = samp_ptr;
                  f_valid_d = 1'b1;
                  if (cnt_inc == CNTW'(DWELL)) begin
                     cnt_d = '0;
                     ptr_d = next_en(en_mask, samp_ptr);
                  end else begin
                     cnt_d = cnt_inc;
                     ptr_d = samp_ptr;
                  end
               end
            end
            default: begin
               f_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         f_q       <= '0;
         f_valid_q <= 1'b0;
         f_ch_q    <= '0;
         sel_err_q <= 1'b0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= MODE_MANUAL;
      end else begin
         f_q       <= f_d;
         f_valid_q <= f_valid_d;
         f_ch_q    <= f_ch_d;
         sel_err_q <= sel_err_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
      end
   end

   assign f       = f_q;
   assign f_valid = f_valid_q;
   assign f_ch    = f_ch_q;
   assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n1.sv
// tb/tb_mux_scan_n1.sv - directed-vector bench for mux_scan_n1 at N=16 and N=12
module tb_mux_scan_n1;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [15:0] w16;
   logic [3:0]  s16;
   logic [1:0]  mode16;
   logic [15:0] mask16;
   logic        rdy16;
   logic [0:0]  f16;
   logic        fv16;
   logic [3:0]  fch16;
   logic        err16;

   logic [11:0] w12;
   logic [3:0]  s12;
   logic [1:0]  mode12;
   logic [11:0] mask12;
   logic        rdy12;
   logic [0:0]  f12;
   logic        fv12;
   logic [3:0]  fch12;
   logic        err12;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clock = ~Clock;

   mux_scan_n1 #(.N(16), .W(1), .DWELL(4)) dut16 (
      .Clock(Clock), .Resetn(Resetn), .w(w16), .s(s16), .mode(mode16), .en_mask(mask16),
      .out_ready(rdy16), .f(f16), .f_valid(fv16), .f_ch(fch16), .sel_err(err16)
   );

   mux_scan_n1 #(.N(12), .W(1), .DWELL(4)) dut12 (
      .Clock(Clock), .Resetn(Resetn), .w(w12), .s(s12), .mode(mode12), .en_mask(mask12),
      .out_ready(rdy12), .f(f12), .f_valid(fv12), .f_ch(fch12), .sel_err(err12)
   );

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      w16 = 16'hFFFF; w12 = 12'hFFF;
      mode16 = 2'b00; mode12 = 2'b00;
      s16 = 4'd5; s12 = 4'd5;
      rdy16 = 1'b1; rdy12 = 1'b1;
      mask16 = 16'hFFFF; mask12 = 12'hFFF;
      tick();
      tick();
      n_vec++;
      if ({f16, fv16, fch16, err16} !== 7'b0) begin
         n_err++;
         $display("FAIL reset16: got f=%0h fv=%0b ch=%0d err=%0b want all 0", f16, fv16, fch16, err16);
      end
      n_vec++;
      if ({f12, fv12, fch12, err12} !== 7'b0) begin
         n_err++;
         $display("FAIL reset12: got f=%0h fv=%0b ch=%0d err=%0b want all 0", f12, fv12, fch12, err12);
      end
      Resetn = 1'b1;
   endtask

   task automatic test_manual();
      w16 = 16'h0020; s16 = 4'd5; mode16 = 2'b00; rdy16 = 1'b1;
      tick();
      n_vec++;
      if ({fv16, fch16, f16} !== {1'b1, 4'd5, 1'b1}) begin
         n_err++;
         $display("FAIL manual_s5: got fv=%0b ch=%0d f=%0b want fv=1 ch=5 f=1", fv16, fch16, f16);
      end
      w16 = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         s16 = 4'(i);
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'(i), w16[i]}) begin
            n_err++;
            $display("FAIL manual_sweep%0d: got fv=%0b ch=%0d f=%0b want fv=1 ch=%0d f=%0b",
                     i, fv16, fch16, f16, i, w16[i]);
         end
      end
   endtask

   task automatic test_scan();
      int exp_ch[14];
      exp_ch = '{0, 0, 0, 0, 4, 4, 4, 4, 8, 8, 8, 8, 0, 0};
      do_reset();
      w16 = 16'h0110; mask16 = 16'h0111; mode16 = 2'b01; rdy16 = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'(exp_ch[i]), w16[exp_ch[i]]}) begin
            n_err++;
            $display("FAIL scan_seq%0d: got fv=%0b ch=%0d f=%0b want fv=1 ch=%0d f=%0b",
                     i, fv16, fch16, f16, exp_ch[i], w16[exp_ch[i]]);
         end
      end
   endtask

   task automatic test_stall();
      int pre[6];
      int post[6];
      pre  = '{0, 0, 0, 0, 4, 4};
      post = '{4, 4, 8, 8, 8, 8};
      do_reset();
      w16 = 16'h0010; mask16 = 16'h0111; mode16 = 2'b01; rdy16 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'(pre[i]), w16[pre[i]]}) begin
            n_err++;
            $display("FAIL stall_pre%0d: got ch=%0d f=%0b want ch=%0d f=%0b",
                     i, fch16, f16, pre[i], w16[pre[i]]);
         end
      end
      rdy16 = 1'b0;
      w16 = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'd4, 1'b1}) begin
            n_err++;
            $display("FAIL stall_hold%0d: got fv=%0b ch=%0d f=%0b want fv=1 ch=4 f=1",
                     i, fv16, fch16, f16);
         end
      end
      rdy16 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'(post[i]), 1'b0}) begin
            n_err++;
            $display("FAIL stall_post%0d: got fv=%0b ch=%0d f=%0b want fv=1 ch=%0d f=0",
                     i, fv16, fch16, f16, post[i]);
         end
      end
   endtask

   task automatic test_sel_err();
      w12 = 12'h008; mode12 = 2'b00; rdy12 = 1'b1; s12 = 4'd13;
      tick();
      n_vec++;
      if ({fv12, err12} !== 2'b01) begin
         n_err++;
         $display("FAIL selerr_s13: got fv=%0b err=%0b want fv=0 err=1", fv12, err12);
      end
      s12 = 4'd3;
      tick();
      n_vec++;
      if ({fv12, fch12, f12, err12} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL selerr_s3: got fv=%0b ch=%0d f=%0b err=%0b want fv=1 ch=3 f=1 err=1",
                  fv12, fch12, f12, err12);
      end
      s12 = 4'd11;
      tick();
      n_vec++;
      if ({fv12, fch12, err12} !== {1'b1, 4'd11, 1'b1}) begin
         n_err++;
         $display("FAIL selerr_s11: got fv=%0b ch=%0d err=%0b want fv=1 ch=11 err=1", fv12, fch12, err12);
      end
   endtask

   task automatic test_mask_zero_and_reset();
      int seq[9];
      seq = '{0, 0, 0, 0, 4, 4, 4, 4, 8};
      do_reset();
      w16 = 16'h0101; mode16 = 2'b01; mask16 = 16'h0000; rdy16 = 1'b1;
      tick();
      n_vec++;
      if (fv16 !== 1'b0) begin
         n_err++;
         $display("FAIL mask0: got fv=%0b want 0", fv16);
      end
      mask16 = 16'h0111;
      for (int i = 0; i < 9; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16, f16} !== {1'b1, 4'(seq[i]), w16[seq[i]]}) begin
            n_err++;
            $display("FAIL mask_resume%0d: got fv=%0b ch=%0d f=%0b want fv=1 ch=%0d f=%0b",
                     i, fv16, fch16, f16, seq[i], w16[seq[i]]);
         end
      end
      Resetn = 1'b0;
      tick();
      n_vec++;
      if ({f16, fv16, fch16, err16} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_midscan: got f=%0h fv=%0b ch=%0d err=%0b want all 0", f16, fv16, fch16, err16);
      end
      Resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16} !== {1'b1, 4'(seq[i])}) begin
            n_err++;
            $display("FAIL post_reset%0d: got fv=%0b ch=%0d want fv=1 ch=%0d", i, fv16, fch16, seq[i]);
         end
      end
   endtask

   task automatic test_skip_and_hold();
      int seq[5];
      seq = '{4, 4, 4, 4, 8};
      do_reset();
      w16 = 16'h0000; mode16 = 2'b01; mask16 = 16'h0111; rdy16 = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({fv16, fch16} !== {1'b1, 4'd0}) begin
         n_err++;
         $display("FAIL skip_pre: got fv=%0b ch=%0d want fv=1 ch=0", fv16, fch16);
      end
      mask16 = 16'h0110;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if ({fv16, fch16} !== {1'b1, 4'(seq[i])}) begin
            n_err++;
            $display("FAIL skip%0d: got fv=%0b ch=%0d want fv=1 ch=%0d", i, fv16, fch16, seq[i]);
         end
      end
      rdy16 = 1'b0; mode16 = 2'b10;
      tick();
      n_vec++;
      if ({fv16, fch16} !== {1'b1, 4'd8}) begin
         n_err++;
         $display("FAIL hold_stall: got fv=%0b ch=%0d want fv=1 ch=8", fv16, fch16);
      end
      rdy16 = 1'b1;
      tick();
      n_vec++;
      if (fv16 !== 1'b0) begin
         n_err++;
         $display("FAIL hold_drain: got fv=%0b want 0", fv16);
      end
      mode16 = 2'b11;
      tick();
      n_vec++;
      if (fv16 !== 1'b0) begin
         n_err++;
         $display("FAIL reserved: got fv=%0b want 0", fv16);
      end
      mode16 = 2'b01;
      tick();
      n_vec++;
      if ({fv16, fch16} !== {1'b1, 4'd4}) begin
         n_err++;
         $display("FAIL scan_reentry: got fv=%0b ch=%0d want fv=1 ch=4", fv16, fch16);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_scan();
      test_stall();
      test_sel_err();
      test_mask_zero_and_reset();
      test_skip_and_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
